regfile_bist: RTL and testbench

- Hardware initiator for the 32x32 register file's write/read-port interface: drives the write port and both read ports, and checks read data against an internally generated pattern.
- Runs a self-test on a start pulse and reports pass/fail, a saturating error count and the first failing location.
- Sits beside the regfile and takes over its control ports during power-on or maintenance test; the regfile is unchanged.

---
 rtl/regfile_bist.sv | 201 ++++++++++++++++++++
 tb/tb_regfile_bist.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bist.sv
// -----------------------------------------------------------------------------
// regfile_bist
//
// Built-in self-test initiator for a 32x32 register file with one write port
// and two combinational read ports. On a start pulse it writes a pattern into
// every register, reads everything back through both read ports and compares.
// It then repeats the write/read sequence with the inverted pattern.
//
// It reports pass/fail, a saturating mismatch count and the first failing
// location.
//
// Register 0 is expected to read back 0. It is still written, and the regfile
// ignores that write.
//
// Ports:
//   clock          - system clock, all state changes on posedge
//   ctrl_reset     - asynchronous active-low reset
//   start          - begin a test; only honoured in IDLE or DONE
//   ctrl_writeEn   - regfile write enable (high only in WRITE)
//   ctrl_writeReg  - regfile write address
//   data_writeReg  - regfile write data
//   ctrl_readRegA  - read port A address
//   ctrl_readRegB  - read port B address (always 31 - port A address)
//   data_readRegA  - read port A data, combinational from the regfile
//   data_readRegB  - read port B data, combinational from the regfile
//   busy           - test in progress
//   done           - test finished, held until the next accepted start
//   pass           - valid while done=1; 1 when no mismatch was seen
//   err_count      - saturating mismatch count
//   first_err_reg  - register of the first mismatch
//   first_err_port - port of the first mismatch (0 = A, 1 = B)
//   dbg_state      - current FSM state (0 IDLE, 1 WRITE, 2 READ, 3 DONE)
//
// Handshake: start is a level sampled on every posedge while the FSM is in
// IDLE or DONE. The first posedge that sees start=1 there accepts the run.
// There is no ready signal; busy=1 tells the caller the request was taken.
// -----------------------------------------------------------------------------
module regfile_bist #(
    parameter logic [31:0] SEED     = 32'hA5A5_0000,
    parameter int          ERR_W    = 8,
    parameter bit          CHECK_R0 = 1'b1
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             start,
    output logic             ctrl_writeEn,
    output logic [4:0]       ctrl_writeReg,
    output logic [31:0]      data_writeReg,
    output logic [4:0]       ctrl_readRegA,
    output logic [4:0]       ctrl_readRegB,
    input  logic [31:0]      data_readRegA,
    input  logic [31:0]      data_readRegB,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [4:0]       first_err_reg,
    output logic             first_err_port,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    state_t           state, state_nxt;
    logic [4:0]       r, r_nxt;
    logic             p, p_nxt;
    logic [ERR_W-1:0] err_q, err_nxt;
    logic [4:0]       ferr_reg_q, ferr_reg_nxt;
    logic             ferr_port_q, ferr_port_nxt;
    logic             ferr_seen_q, ferr_seen_nxt;

    // Pattern for register idx in pass ph: SEED+idx, inverted in the second pass.
    function automatic logic [31:0] pat(input logic [4:0] idx, input logic ph);
        logic [31:0] base;
        base = SEED + {27'd0, idx};
        return ph ? ~base : base;
    endfunction

    // Register 0 is hardwired to zero in the regfile, so it must read back 0.
    function automatic logic [31:0] exp_val(input logic [4:0] idx, input logic ph);
        return (idx == 5'd0) ? 32'd0 : pat(idx, ph);
    endfunction

    // Port B walks downwards; 31 - r is the bitwise inverse of a 5-bit r.
    logic [4:0]   rb;
    logic         chk_a, chk_b;
    logic         mis_a, mis_b;
    logic [ERR_W:0] err_sum;

    always_comb begin
        rb    = ~r;
        chk_a = (state == S_READ) && (CHECK_R0 || (r != 5'd0));
        chk_b = (state == S_READ) && (CHECK_R0 || (rb != 5'd0));
        mis_a = chk_a && (data_readRegA != exp_val(r, p));
        mis_b = chk_b && (data_readRegB != exp_val(rb, p));
        // One extra bit catches overflow; at most 2 is added per cycle, so the
        // carry bit alone says the count has gone past ERR_MAX.
        err_sum = {1'b0, err_q}
                + {{ERR_W{1'b0}}, mis_a}
                + {{ERR_W{1'b0}}, mis_b};
    end

    // State register
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state       <= S_IDLE;
            r           <= 5'd0;
            p           <= 1'b0;
            err_q       <= '0;
            ferr_reg_q  <= 5'd0;
            ferr_port_q <= 1'b0;
            ferr_seen_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            r           <= r_nxt;
            p           <= p_nxt;
            err_q       <= err_nxt;
            ferr_reg_q  <= ferr_reg_nxt;
            ferr_port_q <= ferr_port_nxt;
            ferr_seen_q <= ferr_seen_nxt;
        end
    end

    // Next-state and result update
    always_comb begin
        state_nxt     = state;
        r_nxt         = r;
        p_nxt         = p;
        err_nxt       = err_q;
        ferr_reg_nxt  = ferr_reg_q;
        ferr_port_nxt = ferr_port_q;
        ferr_seen_nxt = ferr_seen_q;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt     = S_WRITE;
                    r_nxt         = 5'd0;
                    p_nxt         = 1'b0;
                    err_nxt       = '0;
                    ferr_reg_nxt  = 5'd0;
                    ferr_port_nxt = 1'b0;
                    ferr_seen_nxt = 1'b0;
                end
            end

            S_WRITE: begin
                r_nxt = r + 5'd1;
                if (r == 5'd31) begin
                    state_nxt = S_READ;
                end
            end

            S_READ: begin
                err_nxt = err_sum[ERR_W] ? ERR_MAX : err_sum[ERR_W-1:0];
                // Port A has priority when both ports miss on the same cycle.
                if (!ferr_seen_q && (mis_a || mis_b)) begin
                    ferr_seen_nxt = 1'b1;
                    ferr_reg_nxt  = mis_a ? r : rb;
                    ferr_port_nxt = !mis_a;
                end
                r_nxt = r + 5'd1;
                if (r == 5'd31) begin
                    if (p) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_WRITE;
                        p_nxt     = 1'b1;
                    end
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from registered state. Reset drives state to IDLE
    // asynchronously, so the write enable and read addresses fall at once.
    always_comb begin
        ctrl_writeEn   = (state == S_WRITE);
        ctrl_writeReg  = (state == S_WRITE) ? r : 5'd0;
        data_writeReg  = (state == S_WRITE) ? pat(r, p) : 32'd0;
        ctrl_readRegA  = (state == S_READ) ? r : 5'd0;
        ctrl_readRegB  = (state == S_READ) ? rb : 5'd0;
        busy           = (state == S_WRITE) || (state == S_READ);
        done           = (state == S_DONE);
        pass           = (state == S_DONE) && (err_q == '0);
        err_count      = err_q;
        first_err_reg  = ferr_reg_q;
        first_err_port = ferr_port_q;
        dbg_state      = state;
    end

endmodule

// File: tb/tb_regfile_bist.sv
// -----------------------------------------------------------------------------
// tb_regfile_bist
//
// Bench for regfile_bist. It has three DUT instances:
//   - default parameters
//   - CHECK_R0=0
//   - ERR_W=6
//
// All three share a behavioural 32x32 regfile model. The model can be put in
// one of four modes:
//   - good
//   - reg 5 bit 3 stuck at 0
//   - reg 0 reads 1
//   - all reads 0
//
// sel chooses which instance owns start and the regfile write port.
// -----------------------------------------------------------------------------
module tb_regfile_bist;

    logic clock;
    logic ctrl_reset;
    logic start;
    int   sel;
    int   mode;

    int n_checks;
    int n_err;

    // Result word per run: {pass, err_count[7:0], first_reg[4:0], first_port, cycles[7:0]}
    localparam int EW = 23;
    logic [EW-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUT instances ----------------
    logic st0, st1, st2;
    assign st0 = start && (sel == 0);
    assign st1 = start && (sel == 1);
    assign st2 = start && (sel == 2);

    logic        we0, we1, we2;
    logic [4:0]  wr0, wr1, wr2;
    logic [31:0] wd0, wd1, wd2;
    logic [4:0]  ra0, ra1, ra2, rb0, rb1, rb2;
    logic [31:0] da0, da1, da2, db0, db1, db2;
    logic        bsy0, bsy1, bsy2, dn0, dn1, dn2, ps0, ps1, ps2;
    logic [7:0]  ec0, ec1;
    logic [5:0]  ec2;
    logic [4:0]  fr0, fr1, fr2;
    logic        fp0, fp1, fp2;
    logic [1:0]  ds0, ds1, ds2;

    regfile_bist dut0 (
        .clock(clock), .ctrl_reset(ctrl_reset), .start(st0),
        .ctrl_writeEn(we0), .ctrl_writeReg(wr0), .data_writeReg(wd0),
        .ctrl_readRegA(ra0), .ctrl_readRegB(rb0),
        .data_readRegA(da0), .data_readRegB(db0),
        .busy(bsy0), .done(dn0), .pass(ps0), .err_count(ec0),
        .first_err_reg(fr0), .first_err_port(fp0), .dbg_state(ds0)
    );

    regfile_bist #(.CHECK_R0(1'b0)) dut1 (
        .clock(clock), .ctrl_reset(ctrl_reset), .start(st1),
        .ctrl_writeEn(we1), .ctrl_writeReg(wr1), .data_writeReg(wd1),
        .ctrl_readRegA(ra1), .ctrl_readRegB(rb1),
        .data_readRegA(da1), .data_readRegB(db1),
        .busy(bsy1), .done(dn1), .pass(ps1), .err_count(ec1),
        .first_err_reg(fr1), .first_err_port(fp1), .dbg_state(ds1)
    );

    regfile_bist #(.ERR_W(6)) dut2 (
        .clock(clock), .ctrl_reset(ctrl_reset), .start(st2),
        .ctrl_writeEn(we2), .ctrl_writeReg(wr2), .data_writeReg(wd2),
        .ctrl_readRegA(ra2), .ctrl_readRegB(rb2),
        .data_readRegA(da2), .data_readRegB(db2),
        .busy(bsy2), .done(dn2), .pass(ps2), .err_count(ec2),
        .first_err_reg(fr2), .first_err_port(fp2), .dbg_state(ds2)
    );

    // ---------------- selected-instance view ----------------
    logic        s_we, s_busy, s_done, s_pass, s_fport;
    logic [4:0]  s_wreg, s_freg;
    logic [31:0] s_wdata;
    logic [7:0]  s_err;
    logic [1:0]  s_state;

    always_comb begin
        s_we = we0; s_wreg = wr0; s_wdata = wd0; s_busy = bsy0; s_done = dn0;
        s_pass = ps0; s_err = ec0; s_freg = fr0; s_fport = fp0; s_state = ds0;
        if (sel == 1) begin
            s_we = we1; s_wreg = wr1; s_wdata = wd1; s_busy = bsy1; s_done = dn1;
            s_pass = ps1; s_err = ec1; s_freg = fr1; s_fport = fp1; s_state = ds1;
        end else if (sel == 2) begin
            s_we = we2; s_wreg = wr2; s_wdata = wd2; s_busy = bsy2; s_done = dn2;
            s_pass = ps2; s_err = {2'b00, ec2}; s_freg = fr2; s_fport = fp2; s_state = ds2;
        end
    end

    // ---------------- regfile model ----------------
    logic [31:0][31:0] mem;

    always @(posedge clock) begin
        if (s_we && (s_wreg != 5'd0)) mem[s_wreg] <= s_wdata;
    end

    function automatic logic [31:0] rf_read(input logic [31:0][31:0] m,
                                            input logic [4:0] a, input int md);
        logic [31:0] v;
        v = (a == 5'd0) ? 32'd0 : m[a];
        if (md == 1 && a == 5'd5) v[3] = 1'b0;
        if (md == 2 && a == 5'd0) v = 32'd1;
        if (md == 3) v = 32'd0;
        return v;
    endfunction

    always_comb begin
        da0 = rf_read(mem, ra0, mode); db0 = rf_read(mem, rb0, mode);
        da1 = rf_read(mem, ra1, mode); db1 = rf_read(mem, rb1, mode);
        da2 = rf_read(mem, ra2, mode); db2 = rf_read(mem, rb2, mode);
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic logic [EW-1:0] mk_exp(input logic ps, input logic [7:0] ec,
                                             input logic [4:0] fr, input logic fp);
        return {ps, ec, fr, fp, 8'd128};
    endfunction

    // ---------------- driver tasks ----------------
    // Called #1 after the accepting edge. Follows the run to done, then pops
    // the expected result and compares.
    task automatic wait_done(input string tag);
        int            cyc;
        int            wcnt;
        logic [31:0]   w7;
        bit            got7;
        logic [EW-1:0] e;
        cyc = 0; wcnt = 0; w7 = '0; got7 = 0;
        if (s_we) wcnt++;
        while (!s_done && cyc < 400) begin
            @(posedge clock); #1;
            cyc++;
            if (s_we) begin
                wcnt++;
                if (s_wreg == 5'd7 && !got7) begin
                    got7 = 1; w7 = s_wdata;
                end
            end
        end
        e = exp_q.pop_front();
        chk({tag, "_cycles"}, cyc, {24'd0, e[7:0]});
        chk({tag, "_we_cycles"}, wcnt, 64);
        chk({tag, "_wr7"}, w7, 32'hA5A5_0007);
        chk({tag, "_pass"}, {31'd0, s_pass}, {31'd0, e[22]});
        chk({tag, "_err"}, {24'd0, s_err}, {24'd0, e[21:14]});
        chk({tag, "_freg"}, {27'd0, s_freg}, {27'd0, e[13:9]});
        chk({tag, "_fport"}, {31'd0, s_fport}, {31'd0, e[8]});
        chk({tag, "_busy"}, {31'd0, s_busy}, 0);
    endtask

    task automatic launch(input int s, input int md, input bit hold);
        sel = s; mode = md;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock); #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic run(input string tag, input int s, input int md, input logic [EW-1:0] e);
        exp_q.push_back(e);
        launch(s, md, 1'b0);
        wait_done(tag);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_ctl"}, {19'd0, we0, wr0, ra0, rb0, bsy0, dn0, ps0}, 0);
        chk({tag, "_wdata"}, wd0, 0);
        chk({tag, "_res"}, {18'd0, ec0, fr0, fp0}, 0);
        chk({tag, "_state"}, {30'd0, ds0}, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0; n_err = 0;
        start = 1'b0; sel = 0; mode = 0; mem = '0;
        ctrl_reset = 1'b0;
        repeat (3) @(negedge clock);
        chk_idle_zero("reset");
        ctrl_reset = 1'b1;
        repeat (2) @(negedge clock);

        run("good",      0, 0, mk_exp(1'b1, 8'd0,   5'd0,  1'b0));
        run("stuck5",    0, 1, mk_exp(1'b0, 8'd2,   5'd5,  1'b0));
        run("r0_chk",    0, 2, mk_exp(1'b0, 8'd4,   5'd0,  1'b0));
        run("r0_nochk",  1, 2, mk_exp(1'b1, 8'd0,   5'd0,  1'b0));
        run("zero_w6",   2, 3, mk_exp(1'b0, 8'd63,  5'd31, 1'b1));

        // Start held high for the whole run and past done
        exp_q.push_back(mk_exp(1'b0, 8'd124, 5'd31, 1'b1));
        launch(0, 3, 1'b1);
        wait_done("held");
        @(posedge clock); #1;
        chk("restart_err_clear", {24'd0, s_err}, 0);
        chk("restart_busy", {31'd0, s_busy}, 1);
        chk("restart_done", {31'd0, s_done}, 0);
        start = 1'b0;
        exp_q.push_back(mk_exp(1'b0, 8'd124, 5'd31, 1'b1));
        wait_done("held2");

        // Reset in the middle of the first READ phase
        launch(0, 0, 1'b0);
        repeat (39) @(posedge clock);
        #3 ctrl_reset = 1'b0;
        #1 chk_idle_zero("midreset");
        @(negedge clock);
        ctrl_reset = 1'b1;
        repeat (5) @(posedge clock);
        #1 chk_idle_zero("idle_after");
        run("fresh", 0, 0, mk_exp(1'b1, 8'd0, 5'd0, 1'b0));

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
